// File: rtl/ccff_prog_pkg.sv
// ccff_prog_pkg: shared types for the configuration-chain programmer.
// Ports: none (package holding the controller state encoding).
package ccff_prog_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ccff_rb_packer.sv
// ccff_rb_packer: packs bits leaving the chain tail into readback words.
// Ports: clk, rst (sync high), clr, sample, bit_in, flush -> word, valid.
module ccff_rb_packer #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              sample,
    input  logic              bit_in,
    input  logic              flush,
    output logic [WORD_W-1:0] word,
    output logic              valid
);
    import ccff_prog_pkg::*;

    localparam int BW = $clog2(WORD_W);

    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] acc_nxt;
    logic [BW-1:0]     cnt;
    logic              full;

    // First sampled bit lands in bit 0; bits not yet sampled stay 0.
    always_comb begin
        acc_nxt      = acc;
        acc_nxt[cnt] = bit_in;
    end

    assign full = (cnt == BW'(WORD_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            word  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (clr) begin
                acc <= '0;
                cnt <= '0;
            end else if (sample) begin
                // flush emits a partial word on the final chain shift
                if (full || flush) begin
                    word  <= acc_nxt;
                    valid <= 1'b1;
                    acc   <= '0;
                    cnt   <= '0;
                end else begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ccff_prog_ctrl.sv
// ccff_prog_ctrl: shifts parallel bitstream words LSB-first into the
// configuration chain, counts CHAIN_LEN shifts and repacks tail bits.
// Ports: prog_clk, pReset, start, bs_data/bs_valid/bs_ready,
// ccff_head, ccff_en, ccff_tail, rb_data/rb_valid, busy, prog_done.
module ccff_prog_ctrl #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              ccff_en,
    input  logic              ccff_tail,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    output logic              busy,
    output logic              prog_done
);
    import ccff_prog_pkg::*;

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int BIT_W = $clog2(WORD_W + 1);

    state_t             state;
    state_t             state_nxt;
    logic [WORD_W-1:0]  sreg;
    logic               sreg_vld;
    logic [BIT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   shift_cnt;
    logic               in_load;
    logic               shift;
    logic               last_bit;
    logic               final_shift;
    logic               accept;
    logic               restart;

    assign in_load     = (state == LOAD);
    assign shift       = in_load & sreg_vld;
    assign last_bit    = shift & (bit_cnt == BIT_W'(1));
    assign final_shift = shift & (shift_cnt == CNT_W'(CHAIN_LEN - 1));
    assign restart     = start & (state != LOAD);

    // Refill on the last bit of a word keeps one shift per cycle,
    // but never past the final chain shift.
    assign bs_ready  = in_load & (~sreg_vld | last_bit) & ~final_shift;
    assign accept    = bs_valid & bs_ready;
    assign ccff_en   = shift;
    assign ccff_head = sreg[0];
    assign prog_done = (state == DONE);
    assign busy      = in_load | rb_valid;

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (final_shift) state_nxt = DONE;
            DONE:    if (start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (pReset || restart) begin
            sreg      <= '0;
            sreg_vld  <= 1'b0;
            bit_cnt   <= '0;
            shift_cnt <= '0;
        end else if (final_shift) begin
            // leftover bits of the current word are dropped
            sreg      <= '0;
            sreg_vld  <= 1'b0;
            bit_cnt   <= '0;
            shift_cnt <= shift_cnt + 1'b1;
        end else begin
            if (accept) begin
                sreg     <= bs_data;
                sreg_vld <= 1'b1;
                bit_cnt  <= BIT_W'(WORD_W);
            end else if (shift) begin
                sreg     <= sreg >> 1;
                sreg_vld <= ~last_bit;
                bit_cnt  <= bit_cnt - 1'b1;
            end
            if (shift) begin
                shift_cnt <= shift_cnt + 1'b1;
            end
        end
    end

    ccff_rb_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .clk    (prog_clk),
        .rst    (pReset),
        .clr    (restart),
        .sample (shift),
        .bit_in (ccff_tail),
        .flush  (final_shift),
        .word   (rb_data),
        .valid  (rb_valid)
    );

endmodule

// File: doc/ccff_prog_ctrl.md
# ccff_prog_ctrl

Configuration-chain programming controller for the fabric's scan-style configuration flip-flop chain of DFFRX1 cells. It accepts the bitstream as parallel words over a valid/ready handshake and shifts it serially, LSB first, into `ccff_head` with a shift enable. It counts exactly `CHAIN_LEN` shifts, reports completion, and repacks the bits leaving `ccff_tail` (the previous configuration) into readback words. It sits between the bitstream source (JTAG/SPI front end or testbench) and the top-level chain head/tail pins.

## Interface
Parameters:
- `CHAIN_LEN`, default 64: total configuration bits in the chain; must be ≥ 1.
- `WORD_W`, default 8: bitstream and readback word width; must be ≥ 2.
- `CNT_W`, derived localparam: $clog2(`CHAIN_LEN`+1).

Ports:
- `prog_clk`  in  1  programming clock; all state updates on its rising edge.
- `pReset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a programming pass.
- `bs_data`  in  `WORD_W`  bitstream word; bit 0 is shifted first.
- `bs_valid`  in  1  `bs_data` is valid.
- `bs_ready`  out  1  controller accepts `bs_data` this cycle.
- `ccff_head`  out  1  serial data into the chain.
- `ccff_en`  out  1  chain shift enable; the chain shifts on the `prog_clk` edge where this is high.
- `ccff_tail`  in  1  serial data leaving the chain.
- `rb_data`  out  `WORD_W`  readback word; first-exited bit is in bit 0.
- `rb_valid`  out  1  one-cycle strobe qualifying `rb_data`; there is no backpressure.
- `busy`  out  1  a programming pass is in progress.
- `prog_done`  out  1  the last pass completed all `CHAIN_LEN` shifts.

## Operation
States:
- IDLE: `start` moves to LOAD and clears all counters.
- LOAD: fetch words and shift bits. The cycle carrying the `CHAIN_LEN`-th shift moves to DONE.
- DONE: `prog_done` held high. `start` moves to LOAD and clears `prog_done`.

Reset values:
- State is IDLE.
- `bs_ready`, `ccff_en`, `ccff_head`, `rb_valid`, `busy` and `prog_done` are 0.
- `rb_data` is 0.

Datapath:
- A `WORD_W`-bit shift register `sreg` with a valid flag and a per-word bit counter.
- A total shift counter `shift_cnt` of width `CNT_W`.

Behaviour in LOAD:
- `bs_ready` = LOAD and (`sreg` empty, or `sreg` is shifting its last bit this cycle). Back-to-back words therefore give one shift per cycle with no bubble.
- A word is accepted when `bs_valid` and `bs_ready` are both high. It loads `sreg` and the first shift happens the following cycle.
- `ccff_en` = LOAD and `sreg` valid. `ccff_head` = `sreg[0]` (combinational from registers, glitch-free on `prog_clk`).
- On each shift, `sreg` shifts right, the bit counter decrements and `shift_cnt` increments.
- When `bs_valid` is low with `sreg` empty, the controller stalls: `ccff_en` stays 0 and the chain holds.

Termination and discards:
- When `shift_cnt` reaches `CHAIN_LEN`, the remaining bits of the current word are discarded and no further words are accepted.
- `bs_ready` is 0 outside LOAD.
- `start` in LOAD is ignored. `start` together with `pReset` is ignored, because reset wins.

Readback:
- On every shift cycle, `ccff_tail` is sampled into the readback packer.
- `rb_valid` pulses the cycle after every `WORD_W`-th sampled bit.
- It also pulses for the final partial word when entering DONE; unfilled upper bits of that word are 0.
- Readback word count = ceil(`CHAIN_LEN`/`WORD_W`).

Status outputs:
- `busy` = LOAD, plus the single cycle of any trailing `rb_valid` pulse.

## Timing
- `start` at cycle t gives LOAD at t+1, with `bs_ready` = 1 at t+1.
- A word accepted at cycle c puts bit 0 on `ccff_head` with `ccff_en` = 1 at c+1. Bit k is shifted at c+1+k.
- Full pass with `bs_valid` held high: `CHAIN_LEN`+1 cycles from the first accept to `prog_done` = 1.
- Readback latency: 1 cycle after the sampling shift.
- `pReset` mid-LOAD returns everything to reset values on the next edge. Chain contents are then undefined and `prog_done` = 0.
- `CHAIN_LEN` < `WORD_W`: only one word is accepted, and its excess bits are discarded.

## Structure
- Package `ccff_prog_pkg`: the state enum (IDLE, LOAD, DONE).
- Sub-module `ccff_rb_packer` (serial-to-parallel readback, with its own bit counter and flush input).
- The shift register and counters stay in the top module.

## Test plan
- `CHAIN_LEN`=16, `WORD_W`=8, words 0xA5 then 0x3C back-to-back:
  - `ccff_head` sequence is 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0.
  - `ccff_en` is high for exactly 16 consecutive cycles.
  - `prog_done` rises 17 cycles after the first accept.
- Chain model preloaded with 0xF00F, two passes:
  - The first pass yields `rb_data` 0x0F then 0xF0.
  - The second pass reads back the first pass's data.
- `CHAIN_LEN`=12, `WORD_W`=8, words 0xFF, 0x0F, 0x55:
  - Only two words are accepted and the last 4 bits of 0x0F are discarded.
  - The third word sees `bs_ready` = 0.
  - The partial readback word has upper 4 bits = 0.
- `bs_valid` toggled randomly:
  - `ccff_en` is low during stalls.
  - The total shift count equals exactly `CHAIN_LEN`.
  - The head bit order is unchanged.
- Behaviour across `start`, reset and DONE:
  - `start` pulsed in LOAD is ignored.
  - `pReset` asserted after 5 shifts returns all outputs to 0.
  - A new `start` then completes a full pass.
  - `start` issued in DONE clears `prog_done` and restarts.
